// File: rtl/jtag_lock_ctrl.sv
// rtl/jtag_lock_ctrl.sv - multi-channel debug-access lock controller with key handshake and lockout
//
// Holds one lock bit per debug channel. Every channel comes out of reset locked.
// A key handshake against the compile-time KEY unlocks all channels. Channels
// can then be re-locked one by one (sticky) or all at once. MAX_FAIL
// consecutive bad keys trap the block in LOCKOUT, and only reset clears it.
//
// Optional feature macro: JTAG_LOCK_TIMEOUT_EN
//   When defined, an idle counter runs in KEY_WAIT and UNLOCKED. It clears on
//   state entry and on any key_valid or lock_wr. TIMEOUT idle cycles relock
//   from UNLOCKED. In KEY_WAIT, TIMEOUT idle cycles count as a bad key.
//
// Ports:
//   clk         in   clock, rising edge
//   resetn      in   asynchronous active-low reset
//   unlock_req  in   start a key handshake (LOCKED only)
//   key_valid   in   key_in presented this cycle (KEY_WAIT only)
//   key_in      in   [KEY_W] candidate key
//   lock_wr     in   sticky-lock write strobe (UNLOCKED only)
//   lock_din    in   [N_CH] channels to lock on lock_wr
//   relock_all  in   lock everything, return to LOCKED
//   lock_status out  [N_CH] per-channel lock, 1 = locked
//   state_o     out  [2] LOCKED=0, KEY_WAIT=1, UNLOCKED=2, LOCKOUT=3
//   key_ready   out  high only in KEY_WAIT
//   fail_cnt    out  [FAIL_W] consecutive bad-key count
//   lockout     out  high only in LOCKOUT
module jtag_lock_ctrl #(
    parameter int unsigned            N_CH     = 4,
    parameter int unsigned            KEY_W    = 32,
    parameter logic [KEY_W-1:0]       KEY      = 32'hA5C3_5A3C,
    parameter int unsigned            MAX_FAIL = 3,
    parameter int unsigned            FAIL_W   = 2,
    parameter int unsigned            TIMEOUT  = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              unlock_req,
    input  logic              key_valid,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              lock_wr,
    input  logic [N_CH-1:0]   lock_din,
    input  logic              relock_all,
    output logic [N_CH-1:0]   lock_status,
    output logic [1:0]        state_o,
    output logic              key_ready,
    output logic [FAIL_W-1:0] fail_cnt,
    output logic              lockout
);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_KEY_WAIT = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_LOCKOUT  = 2'd3
    } state_e;

    localparam logic [N_CH-1:0]   ALL_LOCKED = '1;
    localparam logic [FAIL_W-1:0] FAIL_MAX   = FAIL_W'(MAX_FAIL);

    // Reject parameter sets where the fail counter could wrap before lockout.
    generate
        if (MAX_FAIL < 1 || (1 << FAIL_W) <= MAX_FAIL || TIMEOUT < 1) begin : g_bad_params
            $error("jtag_lock_ctrl: invalid MAX_FAIL/FAIL_W/TIMEOUT");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [N_CH-1:0]   lock_q, lock_d;
    logic [FAIL_W-1:0] fail_q, fail_d;
    logic              key_ready_q, key_ready_d;
    logic              lockout_q, lockout_d;
    logic [FAIL_W-1:0] fail_inc;
    logic              bad_key;

`ifdef JTAG_LOCK_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              timeout_hit;
`endif

    always_comb begin
        state_d  = state_q;
        lock_d   = lock_q;
        fail_d   = fail_q;
        fail_inc = fail_q + FAIL_W'(1);
        bad_key  = 1'b0;
`ifdef JTAG_LOCK_TIMEOUT_EN
        // Fires on the TIMEOUT-th consecutive idle cycle.
        timeout_hit = (idle_q == IDLE_W'(TIMEOUT - 1)) && !key_valid && !lock_wr;
`endif

        case (state_q)
            ST_LOCKED: begin
                lock_d = ALL_LOCKED;
                if (unlock_req) begin
                    state_d = ST_KEY_WAIT;
                end
            end
            ST_KEY_WAIT: begin
                if (relock_all) begin
                    state_d = ST_LOCKED;
                end else if (key_valid) begin
                    if (key_in == KEY) begin
                        state_d = ST_UNLOCKED;
                        lock_d  = '0;
                        fail_d  = '0;
                    end else begin
                        bad_key = 1'b1;
                    end
                end
`ifdef JTAG_LOCK_TIMEOUT_EN
                else if (timeout_hit) begin
                    bad_key = 1'b1;
                end
`endif
                if (bad_key) begin
                    fail_d  = fail_inc;
                    state_d = (fail_inc == FAIL_MAX) ? ST_LOCKOUT : ST_LOCKED;
                end
            end
            ST_UNLOCKED: begin
                if (relock_all) begin
                    lock_d  = ALL_LOCKED;
                    state_d = ST_LOCKED;
                end else if (lock_wr) begin
                    lock_d = lock_q | lock_din;
                    if ((lock_q | lock_din) == ALL_LOCKED) begin
                        state_d = ST_LOCKED;
                    end
                end
`ifdef JTAG_LOCK_TIMEOUT_EN
                else if (timeout_hit) begin
                    lock_d  = ALL_LOCKED;
                    state_d = ST_LOCKED;
                end
`endif
            end
            default: begin
                // LOCKOUT absorbs everything until reset.
                lock_d = ALL_LOCKED;
                fail_d = FAIL_MAX;
            end
        endcase

`ifdef JTAG_LOCK_TIMEOUT_EN
        // Any state change, activity, or being outside the timed states restarts the count.
        if (state_d != state_q || key_valid || lock_wr ||
            !(state_q == ST_KEY_WAIT || state_q == ST_UNLOCKED)) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + IDLE_W'(1);
        end
`endif

        // Flag outputs are registered copies of the next state.
        key_ready_d = (state_d == ST_KEY_WAIT);
        lockout_d   = (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_LOCKED;
            lock_q      <= ALL_LOCKED;
            fail_q      <= '0;
            key_ready_q <= 1'b0;
            lockout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_q      <= lock_d;
            fail_q      <= fail_d;
            key_ready_q <= key_ready_d;
            lockout_q   <= lockout_d;
        end
    end

`ifdef JTAG_LOCK_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    assign lock_status = lock_q;
    assign state_o     = state_q;
    assign key_ready   = key_ready_q;
    assign fail_cnt    = fail_q;
    assign lockout     = lockout_q;

endmodule

// File: tb/tb_jtag_lock_ctrl.sv
// tb/tb_jtag_lock_ctrl.sv - directed self-checking bench for jtag_lock_ctrl
module tb_jtag_lock_ctrl;

    localparam logic [31:0] GOOD_KEY = 32'hA5C3_5A3C;
`ifdef JTAG_LOCK_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        unlock_req = 1'b0;
    logic        key_valid = 1'b0;
    logic [31:0] key_in = '0;
    logic        lock_wr = 1'b0;
    logic [3:0]  lock_din = '0;
    logic        relock_all = 1'b0;
    logic [3:0]  lock_status;
    logic [1:0]  state_o;
    logic        key_ready;
    logic [1:0]  fail_cnt;
    logic        lockout;

    int errors = 0;
    int checks = 0;

    jtag_lock_ctrl #(
        .N_CH(4), .KEY_W(32), .KEY(GOOD_KEY), .MAX_FAIL(3), .FAIL_W(2), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .resetn(resetn), .unlock_req(unlock_req), .key_valid(key_valid),
        .key_in(key_in), .lock_wr(lock_wr), .lock_din(lock_din), .relock_all(relock_all),
        .lock_status(lock_status), .state_o(state_o), .key_ready(key_ready),
        .fail_cnt(fail_cnt), .lockout(lockout)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are stable 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        unlock_req = 1'b0; key_valid = 1'b0; key_in = '0;
        lock_wr = 1'b0; lock_din = '0; relock_all = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        step(); step();
        resetn = 1'b1;
        step();
    endtask

    // LOCKED -> KEY_WAIT -> present one key; leaves inputs idle.
    task automatic handshake(input logic [31:0] k);
        unlock_req = 1'b1; step(); unlock_req = 1'b0;
        key_valid = 1'b1; key_in = k; step();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        repeat (10) step();
        checks++; if (lock_status !== 4'hF) begin errors++; $display("FAIL reset_lock got=%h exp=%h", lock_status, 4'hF); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL reset_fail got=%0d exp=0", fail_cnt); end
        checks++; if (lockout !== 1'b0) begin errors++; $display("FAIL reset_lockout got=%b exp=0", lockout); end
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL reset_key_ready got=%b exp=0", key_ready); end
    endtask

    task automatic test_unlock();
        unlock_req = 1'b1; step(); unlock_req = 1'b0;
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL unlock_kw_state got=%0d exp=1", state_o); end
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL unlock_key_ready got=%b exp=1", key_ready); end
        checks++; if (lock_status !== 4'hF) begin errors++; $display("FAIL unlock_kw_lock got=%h exp=F", lock_status); end
        key_valid = 1'b1; key_in = GOOD_KEY; step(); idle_inputs();
        checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL unlock_state got=%0d exp=2", state_o); end
        checks++; if (lock_status !== 4'h0) begin errors++; $display("FAIL unlock_lock got=%h exp=0", lock_status); end
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL unlock_key_ready_drop got=%b exp=0", key_ready); end
    endtask

    task automatic test_sticky_lock();
        lock_wr = 1'b1; lock_din = 4'b0101; step();
        checks++; if (lock_status !== 4'b0101) begin errors++; $display("FAIL sticky_first got=%b exp=0101", lock_status); end
        checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL sticky_first_state got=%0d exp=2", state_o); end
        lock_din = 4'b0000; step();
        checks++; if (lock_status !== 4'b0101) begin errors++; $display("FAIL sticky_zero got=%b exp=0101", lock_status); end
        lock_din = 4'b1010; step(); idle_inputs();
        checks++; if (lock_status !== 4'hF) begin errors++; $display("FAIL sticky_full got=%h exp=F", lock_status); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL sticky_full_state got=%0d exp=0", state_o); end
        // LOCKED ignores lock_wr, relock_all and key_valid.
        lock_wr = 1'b1; lock_din = 4'h0; relock_all = 1'b1; key_valid = 1'b1; key_in = GOOD_KEY;
        step(); idle_inputs();
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL locked_ignore_state got=%0d exp=0", state_o); end
        checks++; if (lock_status !== 4'hF) begin errors++; $display("FAIL locked_ignore_lock got=%h exp=F", lock_status); end
    endtask

    task automatic test_lockout();
        for (int i = 1; i <= 3; i++) begin
            handshake(32'h0);
            checks++; if (fail_cnt !== 2'(i)) begin errors++; $display("FAIL lockout_fail%0d got=%0d exp=%0d", i, fail_cnt, i); end
            checks++; if (state_o !== ((i == 3) ? 2'd3 : 2'd0)) begin errors++; $display("FAIL lockout_state%0d got=%0d exp=%0d", i, state_o, (i == 3) ? 3 : 0); end
            checks++; if (lockout !== (i == 3)) begin errors++; $display("FAIL lockout_flag%0d got=%b exp=%b", i, lockout, (i == 3)); end
        end
        unlock_req = 1'b1; key_valid = 1'b1; key_in = GOOD_KEY; relock_all = 1'b1; lock_wr = 1'b1;
        step(); step(); idle_inputs();
        checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL lockout_absorb_state got=%0d exp=3", state_o); end
        checks++; if (lock_status !== 4'hF) begin errors++; $display("FAIL lockout_absorb_lock got=%h exp=F", lock_status); end
        checks++; if (fail_cnt !== 2'd3) begin errors++; $display("FAIL lockout_absorb_fail got=%0d exp=3", fail_cnt); end
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL lockout_key_ready got=%b exp=0", key_ready); end
        do_reset();
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL lockout_reset_state got=%0d exp=0", state_o); end
        checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL lockout_reset_fail got=%0d exp=0", fail_cnt); end
        checks++; if (lockout !== 1'b0) begin errors++; $display("FAIL lockout_reset_flag got=%b exp=0", lockout); end
    endtask

    task automatic test_partial_key();
        handshake(32'hA5C3_5A3D);
        checks++; if (fail_cnt !== 2'd1 || state_o !== 2'd0) begin errors++; $display("FAIL partial_lsb got=fail%0d/st%0d exp=fail1/st0", fail_cnt, state_o); end
        handshake(32'h25C3_5A3C);
        checks++; if (fail_cnt !== 2'd2 || state_o !== 2'd0) begin errors++; $display("FAIL partial_msb got=fail%0d/st%0d exp=fail2/st0", fail_cnt, state_o); end
        handshake(GOOD_KEY);
        checks++; if (fail_cnt !== 2'd0 || state_o !== 2'd2) begin errors++; $display("FAIL good_clears_fail got=fail%0d/st%0d exp=fail0/st2", fail_cnt, state_o); end
        do_reset();
    endtask

    task automatic test_priority();
        handshake(GOOD_KEY);
        relock_all = 1'b1; lock_wr = 1'b1; lock_din = 4'b0001; step(); idle_inputs();
        checks++; if (lock_status !== 4'hF) begin errors++; $display("FAIL prio_unl_lock got=%h exp=F", lock_status); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL prio_unl_state got=%0d exp=0", state_o); end
        // Bad key, then relock_all beats a correct key in KEY_WAIT; fail count is kept.
        handshake(32'h1234_5678);
        unlock_req = 1'b1; step(); unlock_req = 1'b0;
        relock_all = 1'b1; key_valid = 1'b1; key_in = GOOD_KEY; step(); idle_inputs();
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL prio_kw_state got=%0d exp=0", state_o); end
        checks++; if (fail_cnt !== 2'd1) begin errors++; $display("FAIL prio_kw_fail got=%0d exp=1", fail_cnt); end
        checks++; if (lock_status !== 4'hF) begin errors++; $display("FAIL prio_kw_lock got=%h exp=F", lock_status); end
    endtask

    task automatic test_reset_mid_handshake();
        unlock_req = 1'b1; step(); unlock_req = 1'b0;
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL midrst_pre_state got=%0d exp=1", state_o); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL midrst_state got=%0d exp=0", state_o); end
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL midrst_key_ready got=%b exp=0", key_ready); end
        checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL midrst_fail got=%0d exp=0", fail_cnt); end
        checks++; if (lock_status !== 4'hF) begin errors++; $display("FAIL midrst_lock got=%h exp=F", lock_status); end
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic test_idle();
        handshake(GOOD_KEY);
`ifdef JTAG_LOCK_TIMEOUT_EN
        repeat (TMO - 1) step();
        checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL tmo_unl_early got=%0d exp=2", state_o); end
        step();
        checks++; if (state_o !== 2'd0 || lock_status !== 4'hF) begin errors++; $display("FAIL tmo_unl got=st%0d/%h exp=st0/F", state_o, lock_status); end
        unlock_req = 1'b1; step(); unlock_req = 1'b0;
        repeat (TMO) step();
        checks++; if (state_o !== 2'd0 || fail_cnt !== 2'd1) begin errors++; $display("FAIL tmo_kw got=st%0d/fail%0d exp=st0/fail1", state_o, fail_cnt); end
`else
        repeat (40) step();
        checks++; if (state_o !== 2'd2 || lock_status !== 4'h0) begin errors++; $display("FAIL idle_unl got=st%0d/%h exp=st2/0", state_o, lock_status); end
        relock_all = 1'b1; step(); relock_all = 1'b0;
        unlock_req = 1'b1; step(); unlock_req = 1'b0;
        repeat (40) step();
        checks++; if (state_o !== 2'd1 || fail_cnt !== 2'd0) begin errors++; $display("FAIL idle_kw got=st%0d/fail%0d exp=st1/fail0", state_o, fail_cnt); end
`endif
        do_reset();
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_sticky_lock();
        test_lockout();
        test_partial_key();
        test_priority();
        test_reset_mid_handshake();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
